// File: rtl/load_store_unit.sv
// Load/store unit: turns load/store instructions into a req/ack data-bus
// transaction, stalls the core until completion, formats load results.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] aluOut,
  input  logic [31:0] storeData,
  output logic [31:0] memData,
  output logic        stall,
  output logic        accessFault,
  output logic        busErr,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busBe,
  input  logic [31:0] busRdata,
  input  logic        busAck
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;

  logic              f3_legal, aligned, legal_start, fault_req, timeout_hit;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c, lane_c, load_fmt_c;

  // Decode the incoming instruction: legality, alignment, lanes, store data
  always_comb begin
    f3_legal = 1'b0;
    aligned  = 1'b0;
    be_c     = 4'b1111;
    wdata_c  = storeData;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = memRead;
      default:                f3_legal = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        aligned = 1'b1;
        be_c    = 4'b0001 << aluOut[1:0];
        wdata_c = {4{storeData[7:0]}};
      end
      2'b01: begin
        aligned = ~aluOut[0];
        be_c    = aluOut[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{storeData[15:0]}};
      end
      2'b10:   aligned = (aluOut[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    legal_start = (memRead ^ memWrite) & f3_legal & aligned;
    fault_req   = (memRead & memWrite) | ((memRead ^ memWrite) & ~(f3_legal & aligned));
  end

  // Select the addressed lane of the read word and extend it
  always_comb begin
    lane_c = busRdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_fmt_c = {{24{lane_c[7]}}, lane_c[7:0]};
      3'b001:  load_fmt_c = {{16{lane_c[15]}}, lane_c[15:0]};
      3'b100:  load_fmt_c = {24'd0, lane_c[7:0]};
      3'b101:  load_fmt_c = {16'd0, lane_c[15:0]};
      default: load_fmt_c = busRdata;
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_LAST);

  // Next-state and register-input logic for the access FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    mem_data_d  = mem_data_q;
    f3_d        = f3_q;
    off_d       = off_q;
    case (state_q)
      S_IDLE: begin
        if (legal_start) begin
          state_d     = S_BUS;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = memWrite;
          bus_addr_d  = {aluOut[31:2], 2'b00};
          bus_wdata_d = wdata_c;
          bus_be_d    = be_c;
          f3_d        = funct3;
          off_d       = aluOut[1:0];
        end else if (fault_req) begin
          mem_data_d = '0;
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (busAck) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) mem_data_d = load_fmt_c;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) mem_data_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      mem_data_q  <= '0;
      f3_q        <= '0;
      off_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      mem_data_q  <= mem_data_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
    end
  end

  // Zero-latency status outputs; held quiet while in reset
  assign stall       = rst_n & (((state_q == S_IDLE) & legal_start) | (state_q == S_BUS));
  assign accessFault = rst_n & (state_q == S_IDLE) & fault_req;
  assign busErr      = (state_q == S_BUS) & ~busAck & timeout_hit;

  assign memData  = mem_data_q;
  assign busReq   = bus_req_q;
  assign busWe    = bus_we_q;
  assign busAddr  = bus_addr_q;
  assign busWdata = bus_wdata_q;
  assign busBe    = bus_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: transaction-level expectations checked
// every cycle, plus literal spot checks on the documented scenarios.
module tb_load_store_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memRead = 1'b0, memWrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] aluOut = 32'd0, storeData = 32'd0;
  logic [31:0] memData, busAddr, busWdata;
  logic        stall, accessFault, busErr, busReq, busWe;
  logic [3:0]  busBe;
  logic [31:0] busRdata = 32'd0;
  logic        busAck = 1'b0;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .aluOut(aluOut), .storeData(storeData),
    .memData(memData), .stall(stall), .accessFault(accessFault),
    .busErr(busErr), .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
    .busWdata(busWdata), .busBe(busBe), .busRdata(busRdata), .busAck(busAck)
  );

  always #5 clk = ~clk;

  // Expected outputs: registered ones (m_*) and zero-latency ones (e_*)
  logic [31:0] m_mem = 0, m_addr = 0, m_wdata = 0;
  logic [3:0]  m_be = 0;
  logic        m_req = 0, m_we = 0;
  logic        e_stall = 0, e_fault = 0, e_err = 0;
  logic        chk_en = 1'b1;
  int          n_chk = 0, n_err = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Compare every output against the model away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", 32'(stall), 32'(e_stall));
      cmp("accessFault", 32'(accessFault), 32'(e_fault));
      cmp("busErr", 32'(busErr), 32'(e_err));
      cmp("busReq", 32'(busReq), 32'(m_req));
      cmp("busWe", 32'(busWe), 32'(m_we));
      cmp("busAddr", busAddr, m_addr);
      cmp("busWdata", busWdata, m_wdata);
      cmp("busBe", 32'(busBe), 32'(m_be));
      cmp("memData", memData, m_mem);
    end
  end

  function automatic logic legal(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a);
    int nbytes;
    if (rd == wr) return 1'b0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    if (wr && f3 > 3'd2) return 1'b0;
    nbytes = 1 << f3[1:0];
    return (int'(a[1:0]) % nbytes) == 0;
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    nbytes = 1 << f3[1:0];
    return 4'(((1 << nbytes) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] sd);
    if (f3[1:0] == 2'd0) return 32'(sd[7:0]) * 32'h01010101;
    if (f3[1:0] == 2'd1) return 32'(sd[15:0]) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off,
                                      input logic [31:0] w);
    logic [31:0] s;
    int v;
    s = w >> (8 * int'(off));
    case (f3)
      3'd0: begin v = int'(s[7:0]);  if (v >= 128)   v -= 256;   return 32'(v); end
      3'd1: begin v = int'(s[15:0]); if (v >= 32768) v -= 65536; return 32'(v); end
      3'd4: return s & 32'h0000_00FF;
      3'd5: return s & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input logic ack);
    memRead = 1'b0; memWrite = 1'b0; busAck = ack; busRdata = 32'h0BAD0BAD;
    e_stall = 1'b0; e_fault = 1'b0; e_err = 1'b0;
  endtask

  task automatic idle(input logic ack);
    step();
    drive_idle(ack);
  endtask

  // One instruction; ack_at = BUS cycle (1-based) carrying busAck, 0 = never
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input int ack_at, input logic [31:0] rdata);
    logic ok, acked;
    int k;
    ok = legal(rd, wr, f3, addr);
    step();
    memRead = rd; memWrite = wr; funct3 = f3; aluOut = addr; storeData = sd;
    busAck = 1'b0; busRdata = 32'hBAD0BAD0;
    e_stall = ok; e_fault = ~ok & (rd | wr); e_err = 1'b0;
    if (!ok) begin
      step();
      if (rd | wr) m_mem = 32'd0;
      drive_idle(1'b0);
      return;
    end
    k = 0;
    acked = 1'b0;
    while (!acked && k < T) begin
      step();
      if (k == 0) begin
        m_req = 1'b1; m_we = wr; m_addr = {addr[31:2], 2'b00};
        m_be = be_of(f3, addr); m_wdata = wdata_of(f3, sd);
      end
      k++;
      acked = (k == ack_at);
      busAck = acked;
      busRdata = acked ? rdata : 32'hBAD0BAD0;
      e_stall = 1'b1; e_fault = 1'b0;
      e_err = (k == T) && !acked;
    end
    step();
    m_req = 1'b0;
    if (rd) m_mem = acked ? fmt(f3, addr[1:0], rdata) : 32'd0;
    busAck = 1'b0; busRdata = 32'hBAD0BAD0;
    e_stall = 1'b0; e_fault = 1'b0; e_err = 1'b0;
  endtask

  initial begin
    // Reset: outputs zero and stall low even with a load presented
    memRead = 1'b1; funct3 = 3'd2; aluOut = 32'h100;
    step(); step();
    memRead = 1'b0;
    step();
    rst_n = 1'b1;
    idle(1'b1);
    idle(1'b0);

    // LW with immediate ack
    access(1, 0, 3'd2, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    cmp("lw_memData", memData, 32'hDEADBEEF);
    cmp("lw_busAddr", busAddr, 32'h100);
    cmp("lw_busBe", 32'(busBe), 32'hF);

    // Byte and halfword lanes
    access(1, 0, 3'd0, 32'h101, 32'h0, 2, 32'h80F17F00);
    cmp("lb101", memData, 32'h0000007F);
    access(1, 0, 3'd0, 32'h103, 32'h0, 1, 32'h80F17F00);
    cmp("lb103", memData, 32'hFFFFFF80);
    access(1, 0, 3'd4, 32'h103, 32'h0, 1, 32'h80F17F00);
    cmp("lbu103", memData, 32'h00000080);
    access(1, 0, 3'd1, 32'h102, 32'h0, 3, 32'h80F17F00);
    cmp("lh102", memData, 32'hFFFF80F1);
    access(1, 0, 3'd5, 32'h100, 32'h0, 1, 32'h80F17F00);
    cmp("lhu100", memData, 32'h00007F00);

    // Stores
    access(0, 1, 3'd1, 32'h202, 32'h1234ABCD, 1, 32'h0);
    cmp("sh_busWe", 32'(busWe), 32'd1);
    cmp("sh_busBe", 32'(busBe), 32'hC);
    cmp("sh_busWdata", busWdata, 32'hABCDABCD);
    cmp("sh_busAddr", busAddr, 32'h200);
    cmp("sh_memData", memData, 32'h00007F00);
    access(0, 1, 3'd0, 32'h203, 32'h000000A5, 2, 32'h0);
    cmp("sb_busWdata", busWdata, 32'hA5A5A5A5);
    access(0, 1, 3'd2, 32'h300, 32'hCAFEF00D, 1, 32'h0);
    idle(1'b0);

    // Faults: misaligned, both strobes, illegal funct3
    access(1, 0, 3'd2, 32'h203, 32'h0, 1, 32'h0);
    cmp("fault_memData", memData, 32'd0);
    access(1, 1, 3'd2, 32'h200, 32'h0, 1, 32'h0);
    access(1, 0, 3'd3, 32'h200, 32'h0, 1, 32'h0);
    access(0, 1, 3'd4, 32'h200, 32'h0, 1, 32'h0);
    access(1, 0, 3'd1, 32'h101, 32'h0, 1, 32'h0);

    // Timeouts and ack on the last allowed cycle
    access(1, 0, 3'd2, 32'h100, 32'h0, 2, 32'h11223344);
    access(1, 0, 3'd2, 32'h400, 32'h0, 0, 32'h0);
    cmp("to_memData", memData, 32'd0);
    access(1, 0, 3'd2, 32'h104, 32'h0, 1, 32'h11223344);
    access(0, 1, 3'd2, 32'h404, 32'h77, 0, 32'h0);
    cmp("to_store_memData", memData, 32'h11223344);
    access(1, 0, 3'd2, 32'h408, 32'h0, T, 32'h55AA55AA);
    cmp("ack_last_memData", memData, 32'h55AA55AA);
    idle(1'b0);

    // Reset two cycles into BUS, then stray acks
    step();
    memRead = 1'b1; memWrite = 1'b0; funct3 = 3'd2; aluOut = 32'h500; busAck = 1'b0;
    e_stall = 1'b1; e_fault = 1'b0; e_err = 1'b0;
    step();
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h500; m_be = 4'hF; m_wdata = 32'h0;
    step();
    rst_n = 1'b0;
    m_req = 1'b0; m_addr = 32'd0; m_be = 4'd0; m_mem = 32'd0;
    e_stall = 1'b0;
    #1;
    cmp("rst_busReq_async", 32'(busReq), 32'd0);
    step();
    drive_idle(1'b1);
    step();
    rst_n = 1'b1;
    drive_idle(1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access unit for the RISC-V core. It sits between the ALU/decoder and the external data bus, directly upstream of the writeback select. It turns load/store instructions into a request/acknowledge bus transaction and stalls the core until the access completes. Load results are byte-lane aligned and sign- or zero-extended, and delivered on `memData` for the writeback select.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of BUS-state cycles without `busAck` before the access is abandoned. Range 1–255; the counter is 8 bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `memRead` in 1: current instruction is a load.
- `memWrite` in 1: current instruction is a store.
- `funct3` in 3: access type.
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
- `aluOut` in 32: effective byte address.
- `storeData` in 32: rs2 value for stores.
- `memData` out 32: formatted load result, registered.
- `stall` out 1: the core must hold PC and suppress register write while this is high.
- `accessFault` out 1: one-cycle pulse on a misaligned access, an illegal `funct3`, or `memRead` and `memWrite` both high.
- `busErr` out 1: one-cycle pulse on bus timeout.
- `busReq` out 1: bus request, registered.
- `busWe` out 1: 1 = write, registered.
- `busAddr` out 32: word address {aluOut[31:2], 2'b00}, registered.
- `busWdata` out 32: lane-replicated store data, registered.
- `busBe` out 4: byte enables, registered. Driven for reads as well.
- `busRdata` in 32: read data, valid only when `busAck`=1.
- `busAck` in 1: transaction complete.

## Operation
- The FSM has three states: IDLE, BUS, DONE.
- **IDLE**
  - If `memRead` xor `memWrite` is high and the access is legal and aligned:
    - latch the bus fields, `funct3` and `aluOut[1:0]`;
    - assert `busReq`;
    - go to BUS.
  - If the access is illegal or misaligned:
    - pulse `accessFault`;
    - drive `memData` to 0;
    - issue no bus transaction and stay in IDLE.
- **Alignment rules**
  - Halfword accesses require addr[0]=0.
  - Word accesses require addr[1:0]=00.
  - Byte accesses are always aligned.
- **Byte enables**
  - Byte: `busBe` = 4'b0001 << addr[1:0].
  - Halfword: `busBe` = addr[1] ? 4'b1100 : 4'b0011.
  - Word: `busBe` = 4'b1111.
- **Store data replication**
  - SB: `busWdata` = {4{storeData[7:0]}}.
  - SH: `busWdata` = {2{storeData[15:0]}}.
  - SW: `busWdata` = `storeData`.
- **BUS**
  - `busReq` and all bus fields stay stable until `busAck`.
  - The timeout counter increments every BUS cycle.
  - On `busAck`:
    - a load captures the formatted `busRdata` into `memData`;
    - a store leaves `memData` unchanged;
    - clear `busReq`;
    - go to DONE.
  - If the counter reaches `TIMEOUT_CYCLES` with no ack:
    - clear `busReq`;
    - pulse `busErr`;
    - set `memData` to 0 for a load;
    - go to DONE.
  - If `busAck` arrives in the same cycle the counter reaches the limit, the ack wins and no `busErr` is raised.
- **Load formatting** (little-endian)
  - Select lane = busRdata >> (8·addr[1:0]).
  - LB / LH sign-extend bit 7 / bit 15.
  - LBU / LHU zero-extend.
  - LW passes the word through.
- **DONE**
  - `stall`=0, so the core retires the instruction at the end of this cycle.
  - Always go to IDLE. DONE never starts a new access, even if `memRead` or `memWrite` is still high.
- **`stall`** is combinational: (IDLE & legal start) | BUS. It is 0 in DONE, in the fault case, and when there is no memory operation.
- **`busAck` outside BUS** is ignored.

## Timing
- **Reset values:**
  - state IDLE, counter 0;
  - `busReq`, `busWe` = 0; `busAddr`, `busWdata` = 0; `busBe` = 0;
  - `memData` = 0; `accessFault`, `busErr` = 0;
  - `stall` = 0 while `rst_n` is low.
- **Minimum access latency** is 3 cycles:
  - cycle 0: IDLE start, `stall`=1;
  - cycle 1: BUS, `busReq`=1, `busAck`=1;
  - cycle 2: DONE, `memData` valid, `stall`=0.
- Each extra cycle of `busAck` delay adds one stall cycle.
- **Timeout path:** `busErr` pulses in the last BUS cycle, so the total stall is TIMEOUT_CYCLES+1 cycles.
- **Fault path:** `accessFault` is a same-cycle, zero-latency combinational pulse; the instruction retires immediately.
- **Reset mid-access:** `busReq` drops immediately (asynchronously) and the FSM returns to IDLE. A late `busAck` after reset is ignored.
- **Back-to-back accesses:** one IDLE cycle separates DONE from the next request.

## Test plan
- **LW, immediate ack:** aluOut=0x100, `busAck` one cycle after `busReq`, busRdata=0xDEADBEEF.
  - `busAddr`=0x100, `busBe`=1111.
  - `stall` high 2 cycles, then `memData`=0xDEADBEEF in DONE.
- **LB / LBU lanes:** busRdata=0x80F17F00, addresses 0x101 and 0x103.
  - LB at 0x101 → 0x0000007F.
  - LB at 0x103 → 0xFFFFFF80.
  - LBU at 0x103 → 0x00000080.
- **SH at 0x202:** storeData=0x1234ABCD.
  - `busWe`=1, `busBe`=1100, `busWdata`=0xABCDABCD, `busAddr`=0x200.
  - `memData` unchanged.
- **Misaligned LW at 0x0203:** `accessFault` pulse, `busReq` never asserts, `stall`=0. Repeat with `memRead`=`memWrite`=1 → same response.
- **Timeout:** TIMEOUT_CYCLES=4, `busAck` held low.
  - `busErr` pulses in the 4th BUS cycle; `memData`=0; `stall` low in the following cycle.
  - Ack on exactly the 4th cycle → no `busErr`.
- **Reset and stray acks:**
  - Assert `rst_n`=0 two cycles into BUS → `busReq` goes to 0 asynchronously and all outputs return to reset values.
  - `busAck` pulses in IDLE produce no state change.
